// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the PC sequencer slice.
//   next_sel_e           : next-PC source, listed from highest to lowest priority
//                          (SEL_RAS is the return-stack flavour of SEL_JR)
//   DEFAULT_RESET_VECTOR : fetch PC after reset
//   DEFAULT_EXC_VECTOR   : trap entry PC
//   DEFAULT_RAS_DEPTH    : return-address-stack entries
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_JR,
    SEL_RAS,
    SEL_SEQ
  } next_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
  localparam int          DEFAULT_RAS_DEPTH    = 4;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry, so the most recent DEPTH return addresses are always kept.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data as the new top
//   pop         : discard the top entry (ignored when empty)
//   push_data   : address to push
//   top         : current top entry
//   count       : number of valid entries, 0..DEPTH
module return_addr_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          push_data,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W:0]   count_q, count_d;

  // sp points at the top entry. Because DEPTH is a power of two the pointer
  // wraps naturally, which gives the overwrite-oldest behaviour for free.
  // A simultaneous push and pop simply rewrites the top in place.
  always_comb begin
    mem_d   = mem_q;
    sp_d    = sp_q;
    count_d = count_q;
    if (push && pop) begin
      mem_d[sp_q] = push_data;
    end else if (push) begin
      sp_d        = sp_q + 1'b1;
      mem_d[sp_d] = push_data;
      if (count_q != FULL) begin
        count_d = count_q + 1'b1;
      end
    end else if (pop && (count_q != '0)) begin
      sp_d    = sp_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // Reset clears the contents too, so nothing from before a reset leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  assign top   = mem_q[sp_q];
  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch-PC sequencer: picks the next PC from exception / eret / jump /
// branch / register-jump / sequential sources, keeps the exception PC and,
// optionally, a return-address stack that predicts register returns.
// Optional feature macro: PC_SEQUENCER_RAS_EN (compiles in the RAS).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pc_enable             : advance enable, 0 stalls every piece of state
//   jump, jea             : J-type redirect and its 26-bit target field
//   pc_src, baddr         : taken branch and its target
//   jump_register, rs_data: register-indirect redirect and its target
//   call                  : push pc+4 onto the RAS
//   ret                   : return hint, meaningful only with jump_register
//   exception, eret       : trap entry / trap return
//   pc, pc4, epc          : current PC, PC+4, saved exception PC
//   ras_count             : valid RAS entries
//   ras_mispredict        : one-cycle pulse after a wrong RAS prediction
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEFAULT_EXC_VECTOR),
  parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_enable,
  input  logic                         jump,
  input  logic [25:0]                  jea,
  input  logic                         pc_src,
  input  logic [XLEN-1:0]              baddr,
  input  logic                         jump_register,
  input  logic [XLEN-1:0]              rs_data,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         exception,
  input  logic                         eret,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc4,
  output logic [XLEN-1:0]              epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_mispredict
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] ras_top;
  logic            ras_hit;
  next_sel_e       sel;

  assign pc4         = pc_q + XLEN'(4);
  assign jump_target = {pc4[XLEN-1:28], jea, 2'b00};

`ifdef PC_SEQUENCER_RAS_EN
  logic                       ras_push, ras_pop;
  logic [$clog2(RAS_DEPTH):0] ras_count_int;
  logic                       mispredict_q, mispredict_d;

  // A trap swallows any call/ret in the same cycle. A return is predicted
  // only when it actually wins the priority race (sel == SEL_RAS).
  assign ras_hit  = ret && (ras_count_int != '0);
  assign ras_push = pc_enable && call && !exception;
  assign ras_pop  = pc_enable && (sel == SEL_RAS);

  return_addr_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc4),
    .top       (ras_top),
    .count     (ras_count_int)
  );

  // The PC always follows the prediction; a mismatch with the real register
  // value is only reported, one cycle later, for the pipeline to recover.
  always_comb begin
    mispredict_d = ras_pop && (ras_top != rs_data);
  end

  // The pulse register updates every cycle so a stall cannot stretch or
  // replay it; the output is additionally masked while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= mispredict_d;
    end
  end

  assign ras_count      = ras_count_int;
  assign ras_mispredict = mispredict_q && pc_enable;
`else
  logic unused_ras_inputs;

  assign ras_hit           = 1'b0;
  assign ras_top           = rs_data;
  assign ras_count         = '0;
  assign ras_mispredict    = 1'b0;
  assign unused_ras_inputs = ^{call, ret};
`endif

  // Fixed-priority source select.
  always_comb begin
    sel = SEL_SEQ;
    if (exception) begin
      sel = SEL_EXC;
    end else if (eret) begin
      sel = SEL_ERET;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (pc_src) begin
      sel = SEL_BRANCH;
    end else if (jump_register) begin
      sel = ras_hit ? SEL_RAS : SEL_JR;
    end
  end

  // Next-state for PC and EPC; both hold while stalled.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (pc_enable) begin
      unique case (sel)
        SEL_EXC: begin
          pc_d  = EXC_VECTOR;
          epc_d = pc_q;
        end
        SEL_ERET:   pc_d = epc_q;
        SEL_JUMP:   pc_d = jump_target;
        SEL_BRANCH: pc_d = baddr;
        SEL_JR:     pc_d = rs_data;
        SEL_RAS:    pc_d = ras_top;
        default:    pc_d = pc4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Table-driven bench for pc_sequencer. Each vector is driven on the falling
// edge, its expected result is queued, and the result is popped and compared
// just after the following rising edge. Expectations for the RAS-dependent
// fields follow the PC_SEQUENCER_RAS_EN macro.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  // control bits: {jump, pc_src, jump_register, call, ret, exception, eret}
  localparam logic [6:0] J    = 7'b1000000;
  localparam logic [6:0] B    = 7'b0100000;
  localparam logic [6:0] JR   = 7'b0010000;
  localparam logic [6:0] CALL = 7'b0001000;
  localparam logic [6:0] RET  = 7'b0000100;
  localparam logic [6:0] EXC  = 7'b0000010;
  localparam logic [6:0] ERET = 7'b0000001;
  localparam logic [6:0] NONE = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_enable, jump, pc_src, jump_register, call, ret, exception, eret;
  logic [25:0] jea;
  logic [31:0] baddr, rs_data;
  logic [31:0] pc, pc4, epc;
  logic [2:0]  ras_count;
  logic        ras_mispredict;

  pc_sequencer #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h80),
    .RAS_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_enable      (pc_enable),
    .jump           (jump),
    .jea            (jea),
    .pc_src         (pc_src),
    .baddr          (baddr),
    .jump_register  (jump_register),
    .rs_data        (rs_data),
    .call           (call),
    .ret            (ret),
    .exception      (exception),
    .eret           (eret),
    .pc             (pc),
    .pc4            (pc4),
    .epc            (epc),
    .ras_count      (ras_count),
    .ras_mispredict (ras_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [6:0]  ctl;
    logic [25:0] jea;
    logic [31:0] baddr;
    logic [31:0] rs;
    logic [31:0] pc_ras;
    logic [31:0] pc_noras;
    logic [31:0] epc;
    int          cnt;
    logic        misp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] cnt;
    logic        misp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic en, input logic [6:0] ctl,
                              input logic [25:0] jea_v, input logic [31:0] baddr_v,
                              input logic [31:0] rs_v, input logic [31:0] pc_v,
                              input logic [31:0] epc_v, input int cnt_v);
    vec_t v;
    v.en = en; v.ctl = ctl; v.jea = jea_v; v.baddr = baddr_v; v.rs = rs_v;
    v.pc_ras = pc_v; v.pc_noras = pc_v; v.epc = epc_v; v.cnt = cnt_v; v.misp = 1'b0;
    return v;
  endfunction

  task automatic checkField(input string name, input int id,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic driveIdle();
    pc_enable = 1'b0; jump = 1'b0; pc_src = 1'b0; jump_register = 1'b0;
    call = 1'b0; ret = 1'b0; exception = 1'b0; eret = 1'b0;
    jea = '0; baddr = '0; rs_data = '0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      checkField("pc",   e.id, pc,  e.pc);
      checkField("pc4",  e.id, pc4, e.pc + 32'd4);
      checkField("epc",  e.id, epc, e.epc);
      checkField("ras_count", e.id, {29'b0, ras_count}, e.cnt);
      checkField("ras_mispredict", e.id, {31'b0, ras_mispredict}, {31'b0, e.misp});
    end
  endtask

  // Drive one vector, optionally pulse reset between the edges, then check.
  task automatic applyStimulus(input vec_t v, input int id, input bit pulse_reset);
    exp_t e;
    @(negedge clk);
    pc_enable     = v.en;
    jump          = v.ctl[6];
    pc_src        = v.ctl[5];
    jump_register = v.ctl[4];
    call          = v.ctl[3];
    ret           = v.ctl[2];
    exception     = v.ctl[1];
    eret          = v.ctl[0];
    jea           = v.jea;
    baddr         = v.baddr;
    rs_data       = v.rs;
    e.id   = id;
    e.pc   = RAS_ON ? v.pc_ras : v.pc_noras;
    e.epc  = v.epc;
    e.cnt  = RAS_ON ? v.cnt : 0;
    e.misp = RAS_ON ? v.misp : 1'b0;
    sb.push_back(e);
    if (pulse_reset) begin
      #2 rst_n = 1'b0;
      #1;
      checkField("async_rst_pc",  id, pc,  32'h0);
      checkField("async_rst_epc", id, epc, 32'h0);
      checkField("async_rst_cnt", id, {29'b0, ras_count}, 32'h0);
      #1 rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    // sequential, jump/branch/register priority, stall, wrap
    vecs.push_back(mk(1, NONE, 0, 0, 0, 32'h4, 0, 0));
    vecs.push_back(mk(1, NONE, 0, 0, 0, 32'h8, 0, 0));
    vecs.push_back(mk(1, NONE, 0, 0, 0, 32'hC, 0, 0));
    vecs.push_back(mk(1, B, 0, 32'h100, 0, 32'h100, 0, 0));
    vecs.push_back(mk(1, J | B, 26'h40, 32'h200, 0, 32'h100, 0, 0));
    vecs.push_back(mk(1, B, 0, 32'h200, 0, 32'h200, 0, 0));
    vecs.push_back(mk(1, B | JR, 0, 32'h400, 32'h500, 32'h400, 0, 0));
    vecs.push_back(mk(1, JR, 0, 0, 32'h500, 32'h500, 0, 0));
    vecs.push_back(mk(0, J, 26'h5, 0, 0, 32'h500, 0, 0));
    vecs.push_back(mk(1, B, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(1, NONE, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, B, 0, 32'h3000_0000, 0, 32'h3000_0000, 0, 0));
    vecs.push_back(mk(1, J, 26'h3, 0, 0, 32'h3000_000C, 0, 0));
    // exception / eret, including stalled trap request
    vecs.push_back(mk(1, B, 0, 32'h300, 0, 32'h300, 0, 0));
    vecs.push_back(mk(0, EXC | CALL, 0, 0, 0, 32'h300, 0, 0));
    vecs.push_back(mk(0, EXC, 0, 0, 0, 32'h300, 0, 0));
    vecs.push_back(mk(1, EXC | CALL, 0, 0, 0, 32'h80, 32'h300, 0));
    vecs.push_back(mk(1, ERET | J, 26'h9, 0, 0, 32'h300, 32'h300, 0));
    vecs.push_back(mk(1, EXC | ERET, 0, 0, 0, 32'h80, 32'h300, 0));
    vecs.push_back(mk(1, ERET, 0, 0, 0, 32'h300, 32'h300, 0));
    // five calls into a 4-deep stack, then five returns
    vecs.push_back(mk(1, B, 0, 32'h10, 0, 32'h10, 32'h300, 0));
    vecs.push_back(mk(1, B | CALL, 0, 32'h20, 0, 32'h20, 32'h300, 1));
    vecs.push_back(mk(1, B | CALL, 0, 32'h30, 0, 32'h30, 32'h300, 2));
    vecs.push_back(mk(1, B | CALL, 0, 32'h40, 0, 32'h40, 32'h300, 3));
    vecs.push_back(mk(1, B | CALL, 0, 32'h50, 0, 32'h50, 32'h300, 4));
    vecs.push_back(mk(1, B | CALL, 0, 32'h1000, 0, 32'h1000, 32'h300, 4));
    vecs.push_back(mk(1, JR | RET, 0, 0, 32'h54, 32'h54, 32'h300, 3));
    vecs.push_back(mk(1, JR | RET, 0, 0, 32'h44, 32'h44, 32'h300, 2));
    vecs.push_back(mk(1, JR | RET, 0, 0, 32'h34, 32'h34, 32'h300, 1));
    vecs.push_back(mk(1, JR | RET, 0, 0, 32'h24, 32'h24, 32'h300, 0));
    vecs.push_back(mk(1, JR | RET, 0, 0, 32'h600, 32'h600, 32'h300, 0));
    // wrong prediction: top 0x24, register says 0x80
    vecs.push_back(mk(1, B, 0, 32'h20, 0, 32'h20, 32'h300, 0));
    vecs.push_back(mk(1, B | CALL, 0, 32'h700, 0, 32'h700, 32'h300, 1));
    v = mk(1, JR | RET, 0, 0, 32'h80, 32'h24, 32'h300, 0);
    v.pc_noras = 32'h80;
    v.misp = 1'b1;
    vecs.push_back(v);
    v = mk(1, NONE, 0, 0, 0, 32'h28, 32'h300, 0);
    v.pc_noras = 32'h84;
    vecs.push_back(v);
    // push+pop together, ret without jump_register, stalled return
    vecs.push_back(mk(1, B, 0, 32'h40, 0, 32'h40, 32'h300, 0));
    vecs.push_back(mk(1, B | CALL, 0, 32'h800, 0, 32'h800, 32'h300, 1));
    vecs.push_back(mk(1, CALL | JR | RET, 0, 0, 32'h44, 32'h44, 32'h300, 1));
    vecs.push_back(mk(1, RET, 0, 0, 32'h999, 32'h48, 32'h300, 1));
    vecs.push_back(mk(0, JR | RET, 0, 0, 32'h999, 32'h48, 32'h300, 1));
    vecs.push_back(mk(1, JR | RET, 0, 0, 32'h804, 32'h804, 32'h300, 0));

    driveIdle();
    rst_n = 1'b0;
    #1;
    checkField("reset_pc",   -1, pc,  32'h0);
    checkField("reset_pc4",  -1, pc4, 32'h4);
    checkField("reset_epc",  -1, epc, 32'h0);
    checkField("reset_cnt",  -1, {29'b0, ras_count}, 32'h0);
    checkField("reset_misp", -1, {31'b0, ras_mispredict}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i, 1'b0);
    end

    // reset pulsed between edges in the middle of a call sequence
    applyStimulus(mk(1, B, 0, 32'h10, 0, 32'h10, 32'h300, 0), 100, 1'b0);
    applyStimulus(mk(1, B | CALL, 0, 32'h20, 0, 32'h20, 32'h300, 1), 101, 1'b0);
    applyStimulus(mk(1, B | CALL, 0, 32'h30, 0, 32'h30, 32'h300, 2), 102, 1'b0);
    applyStimulus(mk(1, JR | RET, 0, 0, 32'h900, 32'h900, 32'h0, 0), 103, 1'b1);
    applyStimulus(mk(1, NONE, 0, 0, 0, 32'h904, 32'h0, 0), 104, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
